// File: rtl/calc_pkg.sv
// Shared encodings and saturation helpers for the calculator accumulator engine.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_UNDO = 2'd3
  } calc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL,
    ST_UNDO,
    ST_REPORT,
    ST_CLR
  } calc_state_e;

  localparam int unsigned MAX_RESULT_WIDTH = 64;

  // Largest positive two's-complement value of a w-bit accumulator.
  function automatic logic [MAX_RESULT_WIDTH-1:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value; only the low w bits are meaningful.
  function automatic logic [MAX_RESULT_WIDTH-1:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/calc_history_stack.sv
// Bounded circular LIFO of previous accumulator values; a push when full drops the oldest.
module calc_history_stack
  import calc_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = 18,
  parameter int unsigned HIST_DEPTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    clear_i,
  input  logic [RESULT_WIDTH-1:0] din_i,
  output logic [RESULT_WIDTH-1:0] dout_o,
  output logic                    empty_o
);

  localparam int unsigned PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HIST_DEPTH);

  logic [RESULT_WIDTH-1:0] mem_q [2**PTR_W];
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !push_i && !clear_i && (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[ptr_q - 1'b1];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (do_push) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[ptr_q] <= din_i;
  end

endmodule

// File: rtl/calc_accumulator_engine.sv
// Saturating signed accumulator with add/sub/shift-add multiply and bounded undo history.
module calc_accumulator_engine
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned RESULT_WIDTH = 18,
  parameter int unsigned HIST_DEPTH   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CLEAR,
  input  logic                    COMPUTE,
  input  logic [1:0]              OPERATION,
  input  logic [DATA_WIDTH-1:0]   CALC_DATA,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    RESULT_READY,
  output logic [RESULT_WIDTH-1:0] RESULT_DATA,
  output logic                    OVERFLOW,
  output logic                    HIST_EMPTY
);

  localparam int unsigned R  = RESULT_WIDTH;
  localparam int unsigned D  = DATA_WIDTH;
  localparam int unsigned PW = R + D;
  localparam int unsigned CW = $clog2(D + 1);

  localparam logic [R-1:0]         SAT_MAX     = R'(sat_max(R));
  localparam logic [R-1:0]         SAT_MIN     = R'(sat_min(R));
  localparam logic signed [R:0]    EXT_MAX     = {1'b0, SAT_MAX};
  localparam logic signed [R:0]    EXT_MIN     = {1'b1, SAT_MIN};
  localparam logic [PW-1:0]        MUL_POS_LIM = {{D{1'b0}}, SAT_MAX};
  localparam logic [PW-1:0]        MUL_NEG_LIM = MUL_POS_LIM + 1'b1;
  localparam logic [CW-1:0]        MUL_LAST    = CW'(D);

  calc_state_e state_q, state_d;
  calc_op_e    op_q, op_d;

  logic [R-1:0]  acc_q, acc_d, result_q, result_d;
  logic [D-1:0]  operand_q, operand_d, mplier_q, mplier_d;
  logic [PW-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d, ovf_int_q, ovf_int_d;
  logic          done_q, done_d, ready_q, ready_d, ovf_q, ovf_d, hempty_q, hempty_d;
  logic          hist_push, hist_pop, hist_empty;
  logic [R-1:0]  hist_dout;

  logic [R-1:0]        acc_mag;
  logic signed [R:0]   acc_ext, opnd_ext, addsub_sum;
  logic                as_hi, as_lo, mul_ovf;
  logic [R-1:0]        addsub_res, mul_res;

  calc_history_stack #(
    .RESULT_WIDTH (R),
    .HIST_DEPTH   (HIST_DEPTH)
  ) u_hist (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (hist_push),
    .pop_i   (hist_pop),
    .clear_i (CLEAR),
    .din_i   (acc_q),
    .dout_o  (hist_dout),
    .empty_o (hist_empty)
  );

  // Magnitude is R-bit unsigned so the most negative value still fits.
  assign acc_mag    = acc_q[R-1] ? (~acc_q + 1'b1) : acc_q;
  assign acc_ext    = {acc_q[R-1], acc_q};
  assign opnd_ext   = {{(R+1-D){1'b0}}, operand_q};
  assign addsub_sum = (op_q == OP_SUB) ? (acc_ext - opnd_ext) : (acc_ext + opnd_ext);
  assign as_hi      = addsub_sum > EXT_MAX;
  assign as_lo      = addsub_sum < EXT_MIN;
  assign addsub_res = as_hi ? SAT_MAX : (as_lo ? SAT_MIN : addsub_sum[R-1:0]);
  assign mul_ovf    = neg_q ? (prod_q > MUL_NEG_LIM) : (prod_q > MUL_POS_LIM);
  assign mul_res    = mul_ovf ? (neg_q ? SAT_MIN : SAT_MAX)
                              : (neg_q ? (~prod_q[R-1:0] + 1'b1) : prod_q[R-1:0]);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (CLEAR) begin
      state_d = ST_CLR;
    end else begin
      unique case (state_q)
        ST_IDLE: if (COMPUTE) begin
          unique case (calc_op_e'(OPERATION))
            OP_ADD, OP_SUB: state_d = ST_ADDSUB;
            OP_MUL:         state_d = ST_MUL;
            OP_UNDO:        state_d = ST_UNDO;
          endcase
        end
        ST_ADDSUB: state_d = ST_REPORT;
        ST_MUL:    if (cnt_q == MUL_LAST) state_d = ST_REPORT;
        ST_UNDO:   state_d = ST_REPORT;
        ST_REPORT: state_d = ST_IDLE;
        ST_CLR:    state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    result_d  = result_q;
    operand_d = operand_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ovf_int_d = ovf_int_q;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    ovf_d     = ovf_q;
    hempty_d  = hempty_q;
    hist_push = 1'b0;
    hist_pop  = 1'b0;
    if (CLEAR) begin
      acc_d     = '0;
      ovf_int_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (COMPUTE) begin
          op_d      = calc_op_e'(OPERATION);
          operand_d = CALC_DATA;
          mplier_d  = CALC_DATA;
          mcand_d   = {{D{1'b0}}, acc_mag};
          prod_d    = '0;
          cnt_d     = '0;
          neg_d     = acc_q[R-1];
          hist_push = (calc_op_e'(OPERATION) != OP_UNDO);
        end
        ST_ADDSUB: begin
          acc_d     = addsub_res;
          ovf_int_d = ovf_int_q | as_hi | as_lo;
        end
        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            acc_d     = mul_res;
            ovf_int_d = ovf_int_q | mul_ovf;
          end else begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        ST_UNDO: if (!hist_empty) begin
          hist_pop = 1'b1;
          acc_d    = hist_dout;
        end
        ST_REPORT: begin
          result_d = acc_q;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          ovf_d    = ovf_int_q;
          hempty_d = hist_empty;
        end
        ST_CLR: begin
          result_d = '0;
          ready_d  = 1'b1;
          ovf_d    = 1'b0;
          hempty_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q      <= OP_ADD;
      acc_q     <= '0;
      result_q  <= '0;
      operand_q <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_int_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
      hempty_q  <= 1'b1;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      operand_q <= operand_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ovf_int_q <= ovf_int_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      ovf_q     <= ovf_d;
      hempty_q  <= hempty_d;
    end
  end

  assign BUSY         = (state_q == ST_ADDSUB) || (state_q == ST_MUL) ||
                        (state_q == ST_UNDO)   || (state_q == ST_REPORT);
  assign DONE         = done_q;
  assign RESULT_READY = ready_q;
  assign RESULT_DATA  = result_q;
  assign OVERFLOW     = ovf_q;
  assign HIST_EMPTY   = hempty_q;

endmodule

// File: tb/tb_calc_accumulator_engine.sv
// Randomized and directed bench for calc_accumulator_engine against a queue-based reference model.
module tb_calc_accumulator_engine;

  localparam int DW = 10;
  localparam int RW = 18;
  localparam int HD = 8;
  localparam longint SMAX = (longint'(1) << (RW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (RW - 1));

  logic          CLK = 1'b0;
  logic          RESET, CLEAR, COMPUTE;
  logic [1:0]    OPERATION;
  logic [DW-1:0] CALC_DATA;
  logic          BUSY, DONE, RESULT_READY, OVERFLOW, HIST_EMPTY;
  logic [RW-1:0] RESULT_DATA;

  int checks = 0;
  int errors = 0;

  longint m_acc;
  bit     m_ovf;
  longint m_hist[$];

  calc_accumulator_engine #(
    .DATA_WIDTH   (DW),
    .RESULT_WIDTH (RW),
    .HIST_DEPTH   (HD)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CLEAR        (CLEAR),
    .COMPUTE      (COMPUTE),
    .OPERATION    (OPERATION),
    .CALC_DATA    (CALC_DATA),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .RESULT_READY (RESULT_READY),
    .RESULT_DATA  (RESULT_DATA),
    .OVERFLOW     (OVERFLOW),
    .HIST_EMPTY   (HIST_EMPTY)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint saturate(input longint v);
    if (v > SMAX) begin m_ovf = 1'b1; return SMAX; end
    if (v < SMIN) begin m_ovf = 1'b1; return SMIN; end
    return v;
  endfunction

  task automatic model_cmd(input int op, input longint d);
    if (op == 3) begin
      if (m_hist.size() > 0) m_acc = m_hist.pop_back();
    end else begin
      if (m_hist.size() == HD) void'(m_hist.pop_front());
      m_hist.push_back(m_acc);
      case (op)
        0:       m_acc = saturate(m_acc + d);
        1:       m_acc = saturate(m_acc - d);
        default: m_acc = saturate(m_acc * d);
      endcase
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_ovf = 1'b0;
    m_hist.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_result"}, $signed(RESULT_DATA), m_acc);
    check({tag, "_ovf"}, OVERFLOW, m_ovf);
    check({tag, "_hempty"}, HIST_EMPTY, m_hist.size() == 0);
  endtask

  // Issues one command, optionally pokes COMPUTE mid-flight, and checks completion timing.
  task automatic apply_cmd(input int op, input int d, input bit inject);
    int lat;
    @(negedge CLK);
    OPERATION = 2'(op);
    CALC_DATA = DW'(d);
    COMPUTE   = 1'b1;
    @(posedge CLK); #1;
    COMPUTE = 1'b0;
    check("busy_after_accept", BUSY, 1);
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (inject && lat == 2 && !DONE) begin
        COMPUTE = 1'b1; OPERATION = 2'd0; CALC_DATA = DW'(1);
      end else begin
        COMPUTE = 1'b0;
      end
    end while (!DONE && lat < 200);
    COMPUTE = 1'b0;
    check("done_latency", lat, (op == 2) ? DW + 2 : 2);
    check("ready_with_done", RESULT_READY, 1);
    check("busy_falls", BUSY, 0);
    model_cmd(op, longint'(d));
    check_state("cmd");
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
    end
    check(tag, dones, 0);
  endtask

  task automatic do_clear();
    @(negedge CLK);
    CLEAR = 1'b1;
    @(posedge CLK); #1;
    CLEAR = 1'b0;
    @(posedge CLK); #1;
    model_clear();
    check("clear_ready", RESULT_READY, 1);
    check("clear_no_done", DONE, 0);
    check_state("clear");
  endtask

  initial begin
    RESET = 1'b1; CLEAR = 1'b0; COMPUTE = 1'b0; OPERATION = '0; CALC_DATA = '0;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ready", RESULT_READY, 0);
    check_state("rst");
    @(negedge CLK);
    RESET = 1'b0;

    apply_cmd(0, 5, 0);
    apply_cmd(1, 12, 0);
    check("neg7_raw", RESULT_DATA, 18'h3FFF9);

    do_clear();
    apply_cmd(0, 300, 0);
    apply_cmd(2, 700, 0);
    check("sat_max", $signed(RESULT_DATA), 131071);
    apply_cmd(1, 1, 0);
    check("sticky_ovf", OVERFLOW, 1);

    do_clear();
    apply_cmd(1, 3, 0);
    apply_cmd(2, 4, 0);
    check("neg_mul", $signed(RESULT_DATA), -12);
    do_clear();
    apply_cmd(1, 256, 0);
    apply_cmd(2, 512, 0);
    apply_cmd(2, 1, 0);
    check("min_no_ovf", OVERFLOW, 0);

    do_clear();
    for (int i = 0; i < 10; i++) apply_cmd($urandom_range(0, 1), $urandom_range(0, 1023), 0);
    for (int i = 0; i < 9; i++) apply_cmd(3, 0, 0);

    // COMPUTE pulsed while a multiply is in flight must be dropped.
    do_clear();
    apply_cmd(0, 21, 0);
    apply_cmd(2, 37, 1);
    quiet_window("busy_compute_dropped", 4);
    check("busy_compute_result", $signed(RESULT_DATA), 777);

    // CLEAR four cycles into a multiply.
    @(negedge CLK);
    OPERATION = 2'd2; CALC_DATA = DW'(9); COMPUTE = 1'b1;
    @(posedge CLK); #1;
    COMPUTE = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    CLEAR = 1'b1;
    @(posedge CLK); #1;
    CLEAR = 1'b0;
    check("midmul_no_done_k", DONE, 0);
    @(posedge CLK); #1;
    model_clear();
    check("midmul_ready", RESULT_READY, 1);
    check("midmul_done", DONE, 0);
    check_state("midmul");
    quiet_window("midmul_quiet", DW + 4);

    // CLEAR and COMPUTE together.
    apply_cmd(0, 50, 0);
    @(negedge CLK);
    CLEAR = 1'b1; COMPUTE = 1'b1; OPERATION = 2'd0; CALC_DATA = DW'(100);
    @(posedge CLK); #1;
    CLEAR = 1'b0; COMPUTE = 1'b0;
    check("both_busy", BUSY, 0);
    quiet_window("both_quiet", DW + 4);
    model_clear();
    check_state("both");

    // RESET mid-operation.
    apply_cmd(0, 77, 0);
    @(negedge CLK);
    OPERATION = 2'd2; CALC_DATA = DW'(5); COMPUTE = 1'b1;
    @(posedge CLK); #1;
    COMPUTE = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_clear();
    check("rstmid_busy", BUSY, 0);
    check("rstmid_done", DONE, 0);
    check("rstmid_ready", RESULT_READY, 0);
    check_state("rstmid");
    quiet_window("rstmid_quiet", DW + 4);

    for (int i = 0; i < 150; i++) begin
      int op;
      int d;
      if ($urandom_range(0, 24) == 0) begin
        do_clear();
      end else begin
        op = $urandom_range(0, 3);
        d  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
        apply_cmd(op, d, 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
